// File: rtl/aes_key_expand_ctrl_pkg.sv
// aes_pkg: shared types, Rcon table, controller state encoding and RotWord helper
package aes_pkg;
   typedef logic [31:0]  word_t;
   typedef logic [127:0] block_t;
   typedef enum logic [2:0] {IDLE, LOAD, SUB, APPLY, DONE} state_t;
   // RCON[i] is the round constant for round i+1
   localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
   function automatic word_t rot_word(input word_t w);
      return {w[23:0], w[31:24]};
   endfunction
endpackage

// File: rtl/aes_key_expand_ctrl_key_schedule.sv
// key_schedule: AES-128 round-key XOR chain
//   k         previous round key (W0 in [127:96])
//   result    SubWord(RotWord(W3)) ^ Rcon
//   round_key next round key
module key_schedule
   import aes_pkg::*;
(
   input  block_t k,
   input  word_t  result,
   output block_t round_key
);
   word_t w0, w1, w2, w3;
   assign w0 = k[127:96] ^ result;
   assign w1 = k[95:64]  ^ w0;
   assign w2 = k[63:32]  ^ w1;
   assign w3 = k[31:0]   ^ w2;
   assign round_key = {w0, w1, w2, w3};
endmodule

// File: rtl/aes_key_expand_ctrl.sv
// aes_key_expand_ctrl: sequences AES-128 key expansion through a shared S-box and stores all round keys
//   clk, rst                 clock, synchronous active-high reset
//   start, key_in            begin expansion of key_in (sampled only in IDLE)
//   busy, done, keys_valid   status: expansion running, final-key pulse, schedule complete
//   sb_req, sb_word_out      S-box request and word to substitute
//   sb_ack, sb_word_in       S-box result handshake
//   rk_idx, rk_out           combinational round-key read port (0 beyond the last key)
module aes_key_expand_ctrl
   import aes_pkg::*;
#(
   parameter int NUM_ROUNDS = 10,
   parameter int KEY_W      = 128
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [KEY_W-1:0] key_in,
   output logic             busy,
   output logic             done,
   output logic             keys_valid,
   output logic             sb_req,
   output logic [31:0]      sb_word_out,
   input  logic             sb_ack,
   input  logic [31:0]      sb_word_in,
   input  logic [3:0]       rk_idx,
   output logic [KEY_W-1:0] rk_out
);
   state_t     state;
   logic [3:0] round;
   logic [3:0] rcon_i;
   block_t     cur_key;
   block_t     round_key;
   word_t      sub_q;
   word_t      ks_result;
   block_t     rk [0:NUM_ROUNDS];

   assign rcon_i    = round - 4'd1;
   assign ks_result = sub_q ^ {RCON[rcon_i], 24'h0};
   assign rk_out    = (rk_idx <= 4'(NUM_ROUNDS)) ? rk[rk_idx] : '0;

   key_schedule u_ks (
      .k         (cur_key),
      .result    (ks_result),
      .round_key (round_key)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         round       <= '0;
         cur_key     <= '0;
         sub_q       <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         keys_valid  <= 1'b0;
         sb_req      <= 1'b0;
         sb_word_out <= '0;
         for (int i = 0; i <= NUM_ROUNDS; i++) rk[i] <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               cur_key    <= key_in;
               keys_valid <= 1'b0;
               busy       <= 1'b1;
               state      <= LOAD;
            end
            LOAD: begin
               rk[0]       <= cur_key;
               round       <= 4'd1;
               sb_req      <= 1'b1;
               sb_word_out <= rot_word(cur_key[31:0]);
               state       <= SUB;
            end
            SUB: if (sb_ack) begin
               sub_q  <= sb_word_in;
               sb_req <= 1'b0;
               state  <= APPLY;
            end
            APPLY: begin
               rk[round] <= round_key;
               cur_key   <= round_key;
               if (round == 4'(NUM_ROUNDS)) begin
                  // done is registered, so it is high exactly while in DONE
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  round       <= round + 4'd1;
                  sb_req      <= 1'b1;
                  sb_word_out <= rot_word(round_key[31:0]);
                  state       <= SUB;
               end
            end
            DONE: begin
               keys_valid <= 1'b1;
               busy       <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_aes_key_expand_ctrl.sv
// tb_aes_key_expand_ctrl: directed FIPS-197 style checks of the key expansion sequencer
module tb_aes_key_expand_ctrl;
   localparam logic [127:0] K1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] K1R1 = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] K1RA = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] K2   = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] K2RA = 128'h13111d7fe3944a17f307a78b4d2b30c5;

   logic         clk = 1'b0;
   logic         rst, start;
   logic [127:0] key_in;
   logic         busy, done, keys_valid, sb_req, sb_ack;
   logic [31:0]  sb_word_out, sb_word_in;
   logic [3:0]   rk_idx;
   logic [127:0] rk_out;
   int           vecs = 0, errs = 0;
   int           sb_delay = 0, wcnt = 0;

   aes_key_expand_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .key_in(key_in),
      .busy(busy), .done(done), .keys_valid(keys_valid),
      .sb_req(sb_req), .sb_word_out(sb_word_out), .sb_ack(sb_ack), .sb_word_in(sb_word_in),
      .rk_idx(rk_idx), .rk_out(rk_out)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00, x = a, y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p ^= x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox8(input logic [7:0] v);
      logic [7:0] inv = 8'h00;
      for (int i = 1; i < 256; i++)
         if (v != 8'h00 && gmul(v, 8'(i)) == 8'h01) inv = 8'(i);
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   assign sb_word_in = {sbox8(sb_word_out[31:24]), sbox8(sb_word_out[23:16]),
                        sbox8(sb_word_out[15:8]), sbox8(sb_word_out[7:0])};
   assign sb_ack = sb_req && (wcnt == sb_delay);
   always @(posedge clk) wcnt <= (sb_req && !sb_ack) ? wcnt + 1 : 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(inout int lat);
      while (!done && lat < 300) begin
         step();
         lat++;
      end
   endtask

   task automatic go(input logic [127:0] k, input int d, output int lat);
      sb_delay = d;
      key_in   = k;
      start    = 1'b1;
      step();
      start = 1'b0;
      lat   = 1;
      wait_done(lat);
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; key_in = '0; rk_idx = '0;
      repeat (3) step();
      rst = 1'b0;
      vecs++;
      if ({busy, done, keys_valid, sb_req} !== 4'b0 || sb_word_out !== 32'h0) begin
         errs++;
         $display("FAIL reset_outputs: got busy=%b done=%b kv=%b req=%b word=%h, want all 0",
                  busy, done, keys_valid, sb_req, sb_word_out);
      end
      for (int i = 0; i < 16; i++) begin
         rk_idx = 4'(i); #1;
         vecs++;
         if (rk_out !== 128'h0) begin
            errs++;
            $display("FAIL reset_rk[%0d]: got %h want 0", i, rk_out);
         end
      end
   endtask

   task automatic test_fips();
      int lat;
      go(K1, 0, lat);
      vecs++;
      if (lat != 22 || busy !== 1'b1) begin
         errs++;
         $display("FAIL fips_latency: got %0d busy=%b want 22 busy=1", lat, busy);
      end
      step();
      vecs++;
      if (keys_valid !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         errs++;
         $display("FAIL fips_idle: got kv=%b busy=%b done=%b want 1 0 0", keys_valid, busy, done);
      end
      rk_idx = 4'd0; #1; vecs++;
      if (rk_out !== K1) begin errs++; $display("FAIL fips_rk0: got %h want %h", rk_out, K1); end
      rk_idx = 4'd1; #1; vecs++;
      if (rk_out !== K1R1) begin errs++; $display("FAIL fips_rk1: got %h want %h", rk_out, K1R1); end
      rk_idx = 4'd10; #1; vecs++;
      if (rk_out !== K1RA) begin errs++; $display("FAIL fips_rk10: got %h want %h", rk_out, K1RA); end
   endtask

   task automatic test_hold();
      int lat;
      sb_delay = 3; key_in = K1; start = 1'b1;
      step();
      start = 1'b0;
      step();
      lat = 2;
      for (int i = 0; i < 3; i++) begin
         vecs++;
         if (sb_req !== 1'b1 || sb_ack !== 1'b0 || sb_word_out !== 32'hcf4f3c09) begin
            errs++;
            $display("FAIL hold_word[%0d]: got req=%b ack=%b word=%h want 1 0 cf4f3c09",
                     i, sb_req, sb_ack, sb_word_out);
         end
         step();
         lat++;
      end
      wait_done(lat);
      vecs++;
      if (lat != 52) begin errs++; $display("FAIL hold_latency: got %0d want 52", lat); end
      step();
   endtask

   task automatic test_delay();
      int lat;
      go(K2, 3, lat);
      vecs++;
      if (lat != 52) begin errs++; $display("FAIL delay_latency: got %0d want 52", lat); end
      step();
      rk_idx = 4'd10; #1; vecs++;
      if (rk_out !== K2RA) begin errs++; $display("FAIL delay_rk10: got %h want %h", rk_out, K2RA); end
      rk_idx = 4'd0; #1; vecs++;
      if (rk_out !== K2) begin errs++; $display("FAIL delay_rk0: got %h want %h", rk_out, K2); end
   endtask

   task automatic test_ignore_start();
      int lat;
      sb_delay = 0; key_in = K1; start = 1'b1;
      step();
      start = 1'b0;
      repeat (4) step();
      key_in = K2; start = 1'b1;
      step();
      start = 1'b0;
      lat = 6;
      wait_done(lat);
      vecs++;
      if (lat != 22) begin errs++; $display("FAIL ignore_latency: got %0d want 22", lat); end
      step();
      rk_idx = 4'd1; #1; vecs++;
      if (rk_out !== K1R1) begin errs++; $display("FAIL ignore_rk1: got %h want %h", rk_out, K1R1); end
      rk_idx = 4'd10; #1; vecs++;
      if (rk_out !== K1RA) begin errs++; $display("FAIL ignore_rk10: got %h want %h", rk_out, K1RA); end
   endtask

   task automatic test_reset_mid();
      int lat;
      sb_delay = 0; key_in = K2; start = 1'b1;
      step();
      start = 1'b0;
      repeat (9) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      vecs++;
      if ({busy, done, keys_valid, sb_req} !== 4'b0 || sb_word_out !== 32'h0) begin
         errs++;
         $display("FAIL midreset_outputs: got busy=%b done=%b kv=%b req=%b word=%h, want all 0",
                  busy, done, keys_valid, sb_req, sb_word_out);
      end
      for (int i = 0; i < 16; i++) begin
         rk_idx = 4'(i); #1;
         vecs++;
         if (rk_out !== 128'h0) begin
            errs++;
            $display("FAIL midreset_rk[%0d]: got %h want 0", i, rk_out);
         end
      end
      go(K1, 0, lat);
      vecs++;
      if (lat != 22) begin errs++; $display("FAIL midreset_restart: got %0d want 22", lat); end
      step();
      rk_idx = 4'd10; #1; vecs++;
      if (rk_out !== K1RA) begin errs++; $display("FAIL midreset_rk10: got %h want %h", rk_out, K1RA); end
   endtask

   task automatic test_bounds();
      int lat;
      rk_idx = 4'd11; #1; vecs++;
      if (rk_out !== 128'h0) begin errs++; $display("FAIL bounds_rk11: got %h want 0", rk_out); end
      rk_idx = 4'd15; #1; vecs++;
      if (rk_out !== 128'h0) begin errs++; $display("FAIL bounds_rk15: got %h want 0", rk_out); end
      rk_idx = 4'd10; #1; vecs++;
      if (rk_out !== K1RA) begin errs++; $display("FAIL bounds_rk10: got %h want %h", rk_out, K1RA); end
      repeat (5) step();
      vecs++;
      if (keys_valid !== 1'b1) begin errs++; $display("FAIL bounds_kv_hold: got %b want 1", keys_valid); end
      key_in = K2; start = 1'b1;
      step();
      start = 1'b0;
      vecs++;
      if (keys_valid !== 1'b0 || busy !== 1'b1) begin
         errs++;
         $display("FAIL bounds_kv_clear: got kv=%b busy=%b want 0 1", keys_valid, busy);
      end
      lat = 1;
      wait_done(lat);
      vecs++;
      if (lat != 22) begin errs++; $display("FAIL bounds_latency: got %0d want 22", lat); end
      step();
   endtask

   initial begin
      test_reset();
      test_fips();
      test_hold();
      test_delay();
      test_ignore_start();
      test_reset_mid();
      test_bounds();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
